obi_rr_arbiter: RTL

- Shares one downstream OBI slave port among NUM_MSTR upstream OBI masters.
- A-channel: round-robin arbitration; the address phase stays stable until granted.
- R-channel: responses return in order and are routed by a FIFO of granted master indices.
- Sits between core/DMA masters and a single memory or peripheral slave; the OBI UVM agent drives and monitors both sides.

---
 rtl/obi_arb_pkg.sv | 13 +
 rtl/obi_arb_idx_fifo.sv | 59 +++++
 rtl/obi_rr_arbiter.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/obi_arb_pkg.sv
// rtl/obi_arb_pkg.sv - shared types for the OBI round-robin arbiter
package obi_arb_pkg;

  localparam int MAX_NUM_MSTR = 8;

  typedef logic [$clog2(MAX_NUM_MSTR)-1:0] idx_t;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } arb_state_e;

endpackage

// File: rtl/obi_arb_idx_fifo.sv
// rtl/obi_arb_idx_fifo.sv - synchronous FIFO of granted master indices
module obi_arb_idx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 1,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  // Explicit wrap keeps DEPTH=1 correct, where the pointer has a spare bit.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
    return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Pointers and occupancy; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/obi_rr_arbiter.sv
// rtl/obi_rr_arbiter.sv - round-robin OBI arbiter, N masters onto one slave
module obi_rr_arbiter
  import obi_arb_pkg::*;
#(
  parameter int NUM_MSTR        = 2,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_MSTR-1:0]            m_req,
  output logic [NUM_MSTR-1:0]            m_gnt,
  input  logic [NUM_MSTR*ADDR_WIDTH-1:0] m_addr,
  input  logic [NUM_MSTR-1:0]            m_we,
  input  logic [NUM_MSTR*DATA_WIDTH/8-1:0] m_be,
  input  logic [NUM_MSTR*DATA_WIDTH-1:0] m_wdata,
  output logic [NUM_MSTR-1:0]            m_rvalid,
  input  logic [NUM_MSTR-1:0]            m_rready,
  output logic [DATA_WIDTH-1:0]          m_rdata,
  output logic                           m_err,
  output logic                           s_req,
  input  logic                           s_gnt,
  output logic [ADDR_WIDTH-1:0]          s_addr,
  output logic                           s_we,
  output logic [DATA_WIDTH/8-1:0]        s_be,
  output logic [DATA_WIDTH-1:0]          s_wdata,
  input  logic                           s_rvalid,
  output logic                           s_rready,
  input  logic [DATA_WIDTH-1:0]          s_rdata,
  input  logic                           s_err,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
  output logic                           err_unexp_rsp
);

  localparam int BE_W = DATA_WIDTH / 8;
  localparam int IW   = $clog2(NUM_MSTR);
  localparam int CW   = $clog2(MAX_OUTSTANDING + 1);

  arb_state_e    state_q;
  idx_t          lock_idx_q, rr_ptr_q;
  logic          err_unexp_q;
  idx_t          rr_sel, sel, head, rr_next;
  logic          req_sel, hs, full, empty, pop, head_rready;
  logic [IW-1:0] fifo_rdata;

  // Round-robin search from rr_ptr upward with wrap; falls back to rr_ptr when idle.
  always_comb begin
    int   j;
    logic found;
    rr_sel = rr_ptr_q;
    found  = 1'b0;
    for (int k = 0; k < NUM_MSTR; k++) begin
      j = (int'(rr_ptr_q) + k) % NUM_MSTR;
      if (!found && m_req[j]) begin
        rr_sel = idx_t'(j);
        found  = 1'b1;
      end
    end
  end

  // While reset is held the mux is forced to master 0 so the bus shows defined slices.
  assign sel = reset ? '0 : ((state_q == LOCKED) ? lock_idx_q : rr_sel);

  // Address-phase mux and request of the selected master.
  always_comb begin
    req_sel = m_req[0];
    s_addr  = m_addr[ADDR_WIDTH-1:0];
    s_we    = m_we[0];
    s_be    = m_be[BE_W-1:0];
    s_wdata = m_wdata[DATA_WIDTH-1:0];
    for (int i = 1; i < NUM_MSTR; i++) begin
      if (sel == idx_t'(i)) begin
        req_sel = m_req[i];
        s_addr  = m_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        s_we    = m_we[i];
        s_be    = m_be[i*BE_W +: BE_W];
        s_wdata = m_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Full blocks requests using registered count only, so rvalid never reaches s_req.
  assign s_req   = ~reset & req_sel & ~full;
  assign hs      = s_req & s_gnt;
  assign rr_next = (sel == idx_t'(NUM_MSTR - 1)) ? '0 : sel + 1'b1;

  // Lock holds the address phase stable from first request until grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= UNLOCKED;
      lock_idx_q <= '0;
      rr_ptr_q   <= '0;
    end else if (hs) begin
      state_q  <= UNLOCKED;
      rr_ptr_q <= rr_next;
    end else if (state_q == UNLOCKED && s_req) begin
      state_q    <= LOCKED;
      lock_idx_q <= sel;
    end
  end

  obi_arb_idx_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (IW),
    .CW    (CW)
  ) u_idx_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (hs),
    .wdata_i (sel[IW-1:0]),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (full),
    .empty_o (empty),
    .count_o (outstanding)
  );

  assign head = idx_t'(fifo_rdata);

  // Response routing to the master at the FIFO head.
  always_comb begin
    head_rready = m_rready[0];
    for (int i = 1; i < NUM_MSTR; i++) begin
      if (head == idx_t'(i)) head_rready = m_rready[i];
    end
    for (int i = 0; i < NUM_MSTR; i++) begin
      m_gnt[i]    = hs & (sel == idx_t'(i));
      m_rvalid[i] = ~reset & s_rvalid & ~empty & (head == idx_t'(i));
    end
  end

  // Unexpected responses are drained when nothing is outstanding.
  assign s_rready = ~reset & (empty ? 1'b1 : head_rready);
  assign pop      = s_rvalid & s_rready & ~empty;
  assign m_rdata  = s_rdata;
  assign m_err    = s_err;

  // Sticky flag for a response arriving with no outstanding transaction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_unexp_q <= 1'b0;
    end else if (s_rvalid && empty) begin
      err_unexp_q <= 1'b1;
    end
  end

  assign err_unexp_rsp = err_unexp_q;

endmodule
